// File: rtl/icache_pkg.sv
// Shared instruction-cache types: bus structs, line geometry, FSM state enum.
// UNCACHED state exists only when ICACHE_UNCACHED_KSEG1_EN is defined.
package icache_pkg;

  localparam int OFFSET_BITS    = 2;
  localparam int LINE_WORDS     = 4;
  localparam int LINE_ADDR_BITS = 28;

  typedef logic [31:0]                   word_t;
  typedef word_t [LINE_WORDS-1:0]        line_t;
  typedef logic [LINE_ADDR_BITS-1:0]     line_addr_t;
  typedef logic [OFFSET_BITS-1:0]        offset_t;

  typedef enum logic [2:0] {
    MSIZE1 = 3'd0,
    MSIZE2 = 3'd1,
    MSIZE4 = 3'd2
  } msize_t;

  typedef enum logic [3:0] {
    MLEN1  = 4'd0,
    MLEN2  = 4'd1,
    MLEN4  = 4'd3,
    MLEN8  = 4'd7,
    MLEN16 = 4'd15
  } mlen_t;

  typedef struct packed {
    logic  valid;
    word_t addr;
  } ibus_req_t;

  typedef struct packed {
    logic  addr_ok;
    logic  data_ok;
    word_t data;
  } ibus_resp_t;

  typedef struct packed {
    logic        valid;
    logic        is_write;
    msize_t      size;
    word_t       addr;
    logic [3:0]  strobe;
    word_t       data;
    mlen_t       len;
  } cbus_req_t;

  typedef struct packed {
    logic  ready;
    logic  last;
    word_t data;
  } cbus_resp_t;

`ifdef ICACHE_UNCACHED_KSEG1_EN
  typedef enum logic [1:0] {IDLE, REFILL, UNCACHED} state_t;
`else
  typedef enum logic [1:0] {IDLE, REFILL} state_t;
`endif

  function automatic logic is_kseg1(input word_t a);
    return a[31:29] == 3'b101;
  endfunction

endpackage

// File: rtl/icache_data_ram.sv
// Line data storage: NUM_SETS x LINE_WORDS words, synchronous write, asynchronous read.
module icache_data_ram
  import icache_pkg::*;
#(
  parameter int NUM_SETS = 16,
  localparam int INDEX_BITS = $clog2(NUM_SETS)
) (
  input  logic                  clk,
  input  logic                  wen,
  input  logic [INDEX_BITS-1:0] widx,
  input  offset_t               woff,
  input  word_t                 wdata,
  input  logic [INDEX_BITS-1:0] ridx,
  input  offset_t               roff,
  output word_t                 rdata
);

  word_t mem [NUM_SETS][LINE_WORDS];

  always_ff @(posedge clk) begin
    if (wen) mem[widx][woff] <= wdata;
  end

  assign rdata = mem[ridx][roff];

endmodule

// File: rtl/icache.sv
// Direct-mapped instruction cache, zero-latency hits, 4-beat line refill on miss.
// Define ICACHE_UNCACHED_KSEG1_EN to bypass the arrays for kseg1 (0xA0000000-0xBFFFFFFF) fetches.
module icache
  import icache_pkg::*;
#(
  parameter int NUM_SETS = 16
) (
  input  logic       clk,
  input  logic       resetn,
  input  ibus_req_t  ireq,
  output ibus_resp_t iresp,
  output cbus_req_t  creq,
  input  cbus_resp_t cresp
);

  localparam int INDEX_BITS = $clog2(NUM_SETS);
  localparam int TAG_BITS   = LINE_ADDR_BITS - INDEX_BITS;

  typedef logic [INDEX_BITS-1:0] index_t;
  typedef logic [TAG_BITS-1:0]   tag_t;

  state_t              state, state_nxt;
  logic [NUM_SETS-1:0] valid_q;
  tag_t                tags [NUM_SETS];
  line_addr_t          line_q;
  offset_t             cnt_q;

  index_t  req_idx;
  tag_t    req_tag;
  offset_t req_off;
  index_t  fill_idx;
  tag_t    fill_tag;
  logic    uncached_req;
  logic    hit;
  logic    fill_wen;
  word_t   hit_data;

  assign req_idx  = ireq.addr[OFFSET_BITS+2 +: INDEX_BITS];
  assign req_tag  = ireq.addr[31 -: TAG_BITS];
  assign req_off  = ireq.addr[3:2];
  assign fill_idx = line_q[INDEX_BITS-1:0];
  assign fill_tag = line_q[LINE_ADDR_BITS-1 -: TAG_BITS];

`ifdef ICACHE_UNCACHED_KSEG1_EN
  word_t uaddr_q;
  assign uncached_req = is_kseg1(ireq.addr);
`else
  assign uncached_req = 1'b0;
`endif

  assign hit      = ireq.valid && !uncached_req && valid_q[req_idx] && (tags[req_idx] == req_tag);
  assign fill_wen = (state == REFILL) && cresp.ready;

  icache_data_ram #(.NUM_SETS(NUM_SETS)) u_data_ram (
    .clk   (clk),
    .wen   (fill_wen),
    .widx  (fill_idx),
    .woff  (cnt_q),
    .wdata (cresp.data),
    .ridx  (req_idx),
    .roff  (req_off),
    .rdata (hit_data)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid_q <= '0;
      line_q  <= '0;
      cnt_q   <= '0;
`ifdef ICACHE_UNCACHED_KSEG1_EN
      uaddr_q <= '0;
`endif
    end else if (state == IDLE) begin
      if (ireq.valid && !hit) begin
        line_q <= ireq.addr[31:4];
`ifdef ICACHE_UNCACHED_KSEG1_EN
        uaddr_q <= ireq.addr;
`endif
      end
    end else if (fill_wen) begin
      cnt_q <= cnt_q + 2'd1;
      // Invalidate up front so a half-written line can never hit.
      if (cnt_q == '0) valid_q[fill_idx] <= 1'b0;
      if (cresp.last) begin
        valid_q[fill_idx] <= 1'b1;
        cnt_q             <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (fill_wen && cresp.last) tags[fill_idx] <= fill_tag;
  end

  always_comb begin
    state_nxt = state;
    iresp     = '0;
    creq      = '0;
    case (state)
      IDLE: begin
        if (hit) begin
          iresp.addr_ok = 1'b1;
          iresp.data_ok = 1'b1;
          iresp.data    = hit_data;
        end else if (ireq.valid) begin
`ifdef ICACHE_UNCACHED_KSEG1_EN
          if (uncached_req) state_nxt = UNCACHED;
          else
`endif
          state_nxt = REFILL;
        end
      end
      REFILL: begin
        creq.valid = 1'b1;
        creq.size  = MSIZE4;
        creq.len   = MLEN4;
        creq.addr  = {line_q, 4'b0000};
        if (cresp.ready && cresp.last) state_nxt = IDLE;
      end
`ifdef ICACHE_UNCACHED_KSEG1_EN
      UNCACHED: begin
        creq.valid = 1'b1;
        creq.size  = MSIZE4;
        creq.len   = MLEN1;
        creq.addr  = uaddr_q;
        if (cresp.ready && cresp.last) begin
          iresp.addr_ok = 1'b1;
          iresp.data_ok = 1'b1;
          iresp.data    = cresp.data;
          state_nxt     = IDLE;
        end
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_icache.sv
// Directed self-checking bench for icache (NUM_SETS=16): cold miss, hits, conflict, ready gaps, reset mid-refill.
module tb_icache;
  import icache_pkg::*;

  logic       clk = 1'b0;
  logic       resetn;
  ibus_req_t  ireq;
  ibus_resp_t iresp;
  cbus_req_t  creq;
  cbus_resp_t cresp;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  icache #(.NUM_SETS(16)) dut (
    .clk    (clk),
    .resetn (resetn),
    .ireq   (ireq),
    .iresp  (iresp),
    .creq   (creq),
    .cresp  (cresp)
  );

`ifdef ICACHE_UNCACHED_KSEG1_EN
  localparam logic [31:0] COLD = 32'h1FC0_0000;
`else
  localparam logic [31:0] COLD = 32'hBFC0_0000;
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Miss on addr a, serve a 4-beat burst (optionally with ready gaps), then expect a hit.
  task automatic fill(input logic [31:0] a, input logic [127:0] w, input bit gaps);
    logic [31:0] line;
    logic [1:0]  off;
    int beats;
    int cyc;
    line = {a[31:4], 4'b0000};
    off  = a[3:2];
    ireq.valid = 1'b1;
    ireq.addr  = a;
    cresp      = '0;
    #1;
    check("miss_no_ok", 32'(iresp.data_ok), 32'd0);
    check("idle_creq_vld", 32'(creq.valid), 32'd0);
    tick();
    check("refill_vld", 32'(creq.valid), 32'd1);
    check("refill_len", 32'(creq.len), 32'(MLEN4));
    check("refill_size", 32'(creq.size), 32'(MSIZE4));
    check("refill_wr", 32'(creq.is_write), 32'd0);
    beats = 0;
    cyc   = 0;
    while (beats < 4 && cyc < 40) begin
      if (gaps && cyc[0]) begin
        ireq.valid = 1'b0;
        ireq.addr  = 32'hDEAD_0000;
        cresp      = '0;
      end else begin
        ireq.valid = 1'b1;
        ireq.addr  = a;
        cresp.ready = 1'b1;
        cresp.last  = (beats == 3);
        cresp.data  = w[32*beats +: 32];
      end
      #1;
      check("burst_addr", creq.addr, line);
      check("burst_vld", 32'(creq.valid), 32'd1);
      check("refill_no_ok", 32'(iresp.data_ok), 32'd0);
      if (cresp.ready) beats++;
      tick();
      cyc++;
    end
    check("burst_beats", beats, 32'd4);
    cresp = '0;
    #1;
    check("retry_hit_ok", 32'(iresp.data_ok), 32'd1);
    check("retry_hit_aok", 32'(iresp.addr_ok), 32'd1);
    check("retry_hit_data", iresp.data, w[32*off +: 32]);
    check("retry_creq_idle", 32'(creq.valid), 32'd0);
  endtask

  task automatic expect_hit(input logic [31:0] a, input logic [31:0] d);
    ireq.valid = 1'b1;
    ireq.addr  = a;
    #1;
    check("hit_ok", 32'(iresp.data_ok), 32'd1);
    check("hit_data", iresp.data, d);
    check("hit_creq_idle", 32'(creq.valid), 32'd0);
    tick();
  endtask

  initial begin
    resetn = 1'b0;
    ireq   = '0;
    cresp  = '0;
    #12;
    check("rst_data_ok", 32'(iresp.data_ok), 32'd0);
    check("rst_addr_ok", 32'(iresp.addr_ok), 32'd0);
    check("rst_creq_vld", 32'(creq.valid), 32'd0);
    check("rst_creq_addr", creq.addr, 32'd0);
    resetn = 1'b1;
    tick();

    // Cold miss then sequential hits in the same line
    fill(COLD, {32'h44, 32'h33, 32'h22, 32'h11}, 1'b0);
    tick();
    expect_hit(COLD + 32'h4, 32'h22);
    expect_hit(COLD + 32'h8, 32'h33);
    expect_hit(COLD + 32'hC, 32'h44);
    ireq.valid = 1'b0;
    #1;
    check("novld_data_ok", 32'(iresp.data_ok), 32'd0);
    check("novld_addr_ok", 32'(iresp.addr_ok), 32'd0);
    tick();

    // Conflict on index 0: second tag evicts the first
    fill(32'h0000_1000, {32'hA3, 32'hA2, 32'hA1, 32'hA0}, 1'b0);
    tick();
    fill(32'h0000_1100, {32'hB3, 32'hB2, 32'hB1, 32'hB0}, 1'b0);
    tick();
    fill(32'h0000_1000, {32'hC3, 32'hC2, 32'hC1, 32'hC0}, 1'b0);
    tick();

    // Ready toggling 1,0,1,0 with the core request wandering meanwhile
    fill(32'h0000_2048, {32'hD3, 32'hD2, 32'hD1, 32'hD0}, 1'b1);
    tick();
    expect_hit(32'h0000_2040, 32'hD0);
    expect_hit(32'h0000_2044, 32'hD1);
    expect_hit(32'h0000_204C, 32'hD3);

    // Reset after two beats of a refill
    ireq.valid = 1'b1;
    ireq.addr  = 32'h0000_3080;
    #1;
    tick();
    for (int i = 0; i < 2; i++) begin
      cresp.ready = 1'b1;
      cresp.last  = 1'b0;
      cresp.data  = 32'hF0 + i;
      tick();
    end
    resetn = 1'b0;
    #1;
    check("midrst_creq_vld", 32'(creq.valid), 32'd0);
    check("midrst_creq_addr", creq.addr, 32'd0);
    check("midrst_data_ok", 32'(iresp.data_ok), 32'd0);
    cresp = '0;
    tick();
    resetn = 1'b1;
    ireq.addr = 32'h0000_2040;
    #1;
    check("postrst_invalid", 32'(iresp.data_ok), 32'd0);
    ireq.valid = 1'b0;
    tick();
    fill(32'h0000_3084, {32'hE3, 32'hE2, 32'hE1, 32'hE0}, 1'b0);
    tick();
    expect_hit(32'h0000_3080, 32'hE0);

`ifdef ICACHE_UNCACHED_KSEG1_EN
    // kseg1 bypass: single beat, never allocated
    for (int rep = 0; rep < 2; rep++) begin
      ireq.valid = 1'b1;
      ireq.addr  = 32'hBFC0_0000;
      cresp      = '0;
      #1;
      check("unc_miss_ok", 32'(iresp.data_ok), 32'd0);
      tick();
      check("unc_creq_vld", 32'(creq.valid), 32'd1);
      check("unc_creq_len", 32'(creq.len), 32'(MLEN1));
      check("unc_creq_addr", creq.addr, 32'hBFC0_0000);
      cresp.ready = 1'b1;
      cresp.last  = 1'b1;
      cresp.data  = 32'h55 + rep;
      #1;
      check("unc_data_ok", 32'(iresp.data_ok), 32'd1);
      check("unc_data", iresp.data, 32'h55 + rep);
      tick();
      cresp = '0;
    end
    ireq.valid = 1'b0;
    tick();
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
